mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Parametrised MEM-stage load/store unit; successor to the combinational lane-select MEM stage.
- Sits between the EX/MEM pipeline register and WB. Drives a data-RAM port that may insert wait states, using a req/ack handshake.
- Generalised data-bus width (32/64); byte/half/word/dword access; misaligned-address detection; pipeline stall while an access is outstanding; registered WB outputs.

Parameters:
- DATA_W, 32, data-bus width; legal values 32 or 64. NB = DATA_W/8 byte lanes.
- ADDR_W, 32, address width.
- REG_W, 7, destination register index width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM slot holds an instruction
- in_ready  out  1  unit can accept an instruction this cycle
- stall  out  1  equals !in_ready; freezes upstream stages
- flush  in  1  kill the in-flight instruction's WB effect
- MemReadM  in  1  load
- MemWriteM  in  1  store
- MemReadType  in  3  [2] sign-extend; [1:0] size: 00 byte, 01 half, 10 word, 11 dword
- ALUout  in  ADDR_W  effective address
- StoreData  in  DATA_W  store data, right-aligned
- RegWriteM, MemtoRegM  in  1 each  pass-through controls
- WriteRegister  in  REG_W  destination register
- PCin  in  32  instruction PC
- mem_req  out  1  bus request
- mem_we  out  NB  byte write strobes; MSB = lane 0
- mem_addr  out  ADDR_W  address, aligned to NB
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_rdata  in  DATA_W  read data, valid while mem_ack is high
- mem_ack  in  1  access complete
- wb_valid  out  1  WB outputs valid this cycle
- RAMout  out  DATA_W  extended load result
- ALUoutW  out  ADDR_W  address pass-through
- RegWriteW, MemtoRegW  out  1 each  controls; RegWriteW forced 0 on exception
- WriteRegisterW  out  REG_W  destination register
- PCout  out  32  PC pass-through
- exc_adel, exc_ades  out  1 each  misaligned load / misaligned store

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; all outputs and internal registers 0; in_ready=1 after reset releases.
- FSM states:
  - IDLE: in_ready=1. If in_valid, evaluate the instruction:
    - Memory op, aligned → latch the request, go to BUS.
    - Non-memory op, or misaligned → load the WB registers at this edge, stay IDLE.
  - BUS: mem_req=1. mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high. On ack: load the WB registers (RAMout from mem_rdata), go to IDLE.
- Latency:
  - Non-memory op: wb_valid one cycle after acceptance.
  - Memory op: earliest mem_req one cycle after acceptance; wb_valid one cycle after the ack edge.
  - Back-to-back issue is allowed on the cycle after returning to IDLE.
- wb_valid is a one-cycle pulse per accepted instruction. WB outputs hold their value until the next load.
- Lane mapping (big-endian): L = ALUout[log2(NB)-1:0]; byte lane L = bits [DATA_W-1-8L -: 8]; strobe bit NB-1-L. Half, word and dword cover lanes L..L+size-1.
- Stores: data is replicated across all lanes of its size; strobes cover only the addressed lanes. Loads: mem_we=0.
- Loads: the selected lanes are right-aligned, then zero-extended (MemReadType[2]=0) or sign-extended (=1) to DATA_W.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
- Violation: no bus request is made. wb_valid=1 with exc_adel (load) or exc_ades (store) set and RegWriteW=0.
- DATA_W=32 with size 11: treated as word.
- MemReadM and MemWriteM both 1: treated as a store.
- flush:
  - In IDLE with in_valid: instruction is discarded, no wb_valid.
  - In BUS: the bus access completes normally (no abort); the resulting wb_valid is suppressed.
  - flush in the ack cycle suppresses that wb_valid.
- mem_ack outside BUS is ignored.
- mem_ack in the same cycle mem_req first rises is legal (zero-wait-state RAM).

Test Plan:
- DATA_W=32, lb, addr 0x1001, rdata 0x11F23344, ack after 3 waits → mem_addr 0x1000; RAMout 0xFFFFFFF2; wb_valid exactly 1 cycle; stall high for 4 cycles.
- sh, addr 0x2002, StoreData 0x0000ABCD, ack immediate → mem_wdata 0xABCDABCD, mem_we 0011; next instruction accepted the cycle after return to IDLE.
- DATA_W=64, ld addr 0x8, rdata 0x0123456789ABCDEF → RAMout 0x0123456789ABCDEF, mem_we 0; lhu addr 0xE, same rdata → 0x000000000000CDEF.
- lw addr 0x3002 → no mem_req; wb_valid=1, exc_adel=1, RegWriteW=0; sw addr 0x3001 → exc_ades=1.
- Load in BUS with flush pulsed at wait cycle 2 → mem_req held until ack; no wb_valid; following ALU op gives wb_valid one cycle after acceptance.
- rst asserted low while in BUS → mem_req, wb_valid and stall drop immediately (asynchronous); after release, in_ready=1 and late mem_ack is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a req/ack data-RAM port and registers the WB outputs.
// Big-endian lane mapping; misaligned accesses raise exc_adel/exc_ades without a bus request.
module mem_access_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  stall,
    input  logic                  flush,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            MemReadType,
    input  logic [ADDR_W-1:0]     ALUout,
    input  logic [DATA_W-1:0]     StoreData,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic [REG_W-1:0]      WriteRegister,
    input  logic [31:0]           PCin,
    output logic                  mem_req,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     RAMout,
    output logic [ADDR_W-1:0]     ALUoutW,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic [REG_W-1:0]      WriteRegisterW,
    output logic [31:0]           PCout,
    output logic                  exc_adel,
    output logic                  exc_ades
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned LaneW = $clog2(NB);

    typedef enum logic {StIdle, StBus} state_e;

    state_e stateQ, stateD;

    // Request and pass-through fields held for the duration of the bus access
    logic [ADDR_W-1:0] reqAddrQ, reqAddrD;
    logic [NB-1:0]     reqWeQ, reqWeD;
    logic [DATA_W-1:0] reqWdataQ, reqWdataD;
    logic [LaneW-1:0]  laneQ, laneD;
    logic [1:0]        sizeQ, sizeD;
    logic              signQ, signD;
    logic              isLoadQ, isLoadD;
    logic              flushQ, flushD;
    logic [ADDR_W-1:0] aluQ, aluD;
    logic              regWriteQ, regWriteD;
    logic              memtoRegQ, memtoRegD;
    logic [REG_W-1:0]  wrRegQ, wrRegD;
    logic [31:0]       pcQ, pcD;

    logic              wbValidQ, wbValidD;
    logic [DATA_W-1:0] ramOutQ, ramOutD;
    logic [ADDR_W-1:0] aluWQ, aluWD;
    logic              regWriteWQ, regWriteWD;
    logic              memtoRegWQ, memtoRegWD;
    logic [REG_W-1:0]  wrRegWQ, wrRegWD;
    logic [31:0]       pcWQ, pcWD;
    logic              adelQ, adelD;
    logic              adesQ, adesD;

    logic [1:0]        sizeIn;
    logic [2:0]        alignMask;
    logic              isMem;
    logic              misaligned;
    logic [NB-1:0]     weIn;
    logic [DATA_W-1:0] wdataIn;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] loadMask;
    logic [DATA_W-1:0] loadData;
    int unsigned       keepBits;

    // Decode of the instruction presented by EX/MEM
    always_comb begin
        sizeIn = MemReadType[1:0];
        if (DATA_W == 32 && sizeIn == 2'b11) begin
            sizeIn = 2'b10;
        end
        alignMask  = 3'((4'd1 << sizeIn) - 4'd1);
        isMem      = MemReadM | MemWriteM;
        misaligned = isMem && ((ALUout[2:0] & alignMask) != 3'b000);
        weIn       = ({NB{1'b1}} << (NB - (32'd1 << sizeIn))) >> ALUout[LaneW-1:0];
        wdataIn    = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            wdataIn[8*b +: 8] = StoreData[8*(b & ((32'd1 << sizeIn) - 32'd1)) +: 8];
        end
    end

    // Lane L sits at the top after shifting left by 8L; right-align by the unused width
    always_comb begin
        shifted  = mem_rdata << {laneQ, 3'b000};
        keepBits = DATA_W - (32'd8 << sizeQ);
        loadMask = {DATA_W{1'b1}} >> keepBits;
        loadData = shifted >> keepBits;
        if (signQ && shifted[DATA_W-1]) begin
            loadData = loadData | ~loadMask;
        end
    end

    always_comb begin
        stateD     = stateQ;
        reqAddrD   = reqAddrQ;
        reqWeD     = reqWeQ;
        reqWdataD  = reqWdataQ;
        laneD      = laneQ;
        sizeD      = sizeQ;
        signD      = signQ;
        isLoadD    = isLoadQ;
        flushD     = flushQ;
        aluD       = aluQ;
        regWriteD  = regWriteQ;
        memtoRegD  = memtoRegQ;
        wrRegD     = wrRegQ;
        pcD        = pcQ;
        wbValidD   = 1'b0;
        ramOutD    = ramOutQ;
        aluWD      = aluWQ;
        regWriteWD = regWriteWQ;
        memtoRegWD = memtoRegWQ;
        wrRegWD    = wrRegWQ;
        pcWD       = pcWQ;
        adelD      = adelQ;
        adesD      = adesQ;

        unique case (stateQ)
            StIdle: begin
                if (in_valid && !flush) begin
                    if (isMem && !misaligned) begin
                        stateD    = StBus;
                        reqAddrD  = {ALUout[ADDR_W-1:LaneW], {LaneW{1'b0}}};
                        reqWeD    = MemWriteM ? weIn : '0;
                        reqWdataD = wdataIn;
                        laneD     = ALUout[LaneW-1:0];
                        sizeD     = sizeIn;
                        signD     = MemReadType[2];
                        isLoadD   = ~MemWriteM;
                        flushD    = 1'b0;
                        aluD      = ALUout;
                        regWriteD = RegWriteM;
                        memtoRegD = MemtoRegM;
                        wrRegD    = WriteRegister;
                        pcD       = PCin;
                    end else begin
                        wbValidD   = 1'b1;
                        ramOutD    = '0;
                        aluWD      = ALUout;
                        regWriteWD = RegWriteM & ~misaligned;
                        memtoRegWD = MemtoRegM;
                        wrRegWD    = WriteRegister;
                        pcWD       = PCin;
                        adelD      = misaligned & ~MemWriteM;
                        adesD      = misaligned & MemWriteM;
                    end
                end
            end
            StBus: begin
                if (flush) begin
                    flushD = 1'b1;
                end
                if (mem_ack) begin
                    stateD = StIdle;
                    // A flushed access still finishes on the bus but never reaches WB
                    if (!flushQ && !flush) begin
                        wbValidD   = 1'b1;
                        ramOutD    = isLoadQ ? loadData : '0;
                        aluWD      = aluQ;
                        regWriteWD = regWriteQ;
                        memtoRegWD = memtoRegQ;
                        wrRegWD    = wrRegQ;
                        pcWD       = pcQ;
                        adelD      = 1'b0;
                        adesD      = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ     <= StIdle;
            reqAddrQ   <= '0;
            reqWeQ     <= '0;
            reqWdataQ  <= '0;
            laneQ      <= '0;
            sizeQ      <= '0;
            signQ      <= 1'b0;
            isLoadQ    <= 1'b0;
            flushQ     <= 1'b0;
            aluQ       <= '0;
            regWriteQ  <= 1'b0;
            memtoRegQ  <= 1'b0;
            wrRegQ     <= '0;
            pcQ        <= '0;
            wbValidQ   <= 1'b0;
            ramOutQ    <= '0;
            aluWQ      <= '0;
            regWriteWQ <= 1'b0;
            memtoRegWQ <= 1'b0;
            wrRegWQ    <= '0;
            pcWQ       <= '0;
            adelQ      <= 1'b0;
            adesQ      <= 1'b0;
        end else begin
            stateQ     <= stateD;
            reqAddrQ   <= reqAddrD;
            reqWeQ     <= reqWeD;
            reqWdataQ  <= reqWdataD;
            laneQ      <= laneD;
            sizeQ      <= sizeD;
            signQ      <= signD;
            isLoadQ    <= isLoadD;
            flushQ     <= flushD;
            aluQ       <= aluD;
            regWriteQ  <= regWriteD;
            memtoRegQ  <= memtoRegD;
            wrRegQ     <= wrRegD;
            pcQ        <= pcD;
            wbValidQ   <= wbValidD;
            ramOutQ    <= ramOutD;
            aluWQ      <= aluWD;
            regWriteWQ <= regWriteWD;
            memtoRegWQ <= memtoRegWD;
            wrRegWQ    <= wrRegWD;
            pcWQ       <= pcWD;
            adelQ      <= adelD;
            adesQ      <= adesD;
        end
    end

    assign in_ready       = (stateQ == StIdle);
    assign stall          = ~in_ready;
    assign mem_req        = (stateQ == StBus);
    assign mem_we         = reqWeQ;
    assign mem_addr       = reqAddrQ;
    assign mem_wdata      = reqWdataQ;
    assign wb_valid       = wbValidQ;
    assign RAMout         = ramOutQ;
    assign ALUoutW        = aluWQ;
    assign RegWriteW      = regWriteWQ;
    assign MemtoRegW      = memtoRegWQ;
    assign WriteRegisterW = wrRegWQ;
    assign PCout          = pcWQ;
    assign exc_adel       = adelQ;
    assign exc_ades       = adesQ;

endmodule
